// File: rtl/trisc_control_sequencer_pkg.sv
// TRISC control sequencer shared definitions.
// Opcode bit positions, ALU function codes and sequencer states.
package trisc_ctrl_pkg;

  localparam int ID_W = 11;

  localparam int ID_LDA = 0;
  localparam int ID_STA = 1;
  localparam int ID_ADD = 2;
  localparam int ID_SUB = 3;
  localparam int ID_XOR = 4;
  localparam int ID_INC = 5;
  localparam int ID_CLR = 6;
  localparam int ID_JMP = 7;
  localparam int ID_JPZ = 8;
  localparam int ID_JPN = 9;
  localparam int ID_HLT = 10;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_XOR  = 3'd3,
    ALU_INC  = 3'd4,
    ALU_CLR  = 3'd5
  } alu_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH0 = 3'd1,
    S_FETCH1 = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

endpackage

// File: rtl/trisc_control_sequencer_onehot.sv
// Opcode vector classifier.
// Flags an all-zero vector and an exactly-one-bit-set vector.
module id_onehot_check
  import trisc_ctrl_pkg::*;
(
  input  logic [ID_W-1:0] id,
  output logic            is_zero,
  output logic            is_onehot
);

  logic [ID_W-1:0] id_m1;

  // clearing the lowest set bit leaves zero only for a single-bit vector
  always_comb begin
    id_m1     = id - ID_W'(1);
    is_zero   = ~|id;
    is_onehot = (|id) & ~|(id & id_m1);
  end

endmodule

// File: rtl/trisc_control_sequencer.sv
// TRISC fetch/decode/execute sequencer.
// Registered state, combinational datapath strobes, retire counter.
module trisc_control_sequencer
  import trisc_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic [10:0]      ID,
  input  logic             Z,
  input  logic             N,
  output logic             PC_INC,
  output logic             PC_LD,
  output logic             MAR_LD,
  output logic             MAR_SRC,
  output logic             IR_LD,
  output logic             MEM_RD,
  output logic             MEM_WR,
  output logic             ACC_LD,
  output logic [2:0]       ALU_SEL,
  output logic             HALTED,
  output logic             ILLEGAL,
  output logic [2:0]       STATE,
  output logic [CNT_W-1:0] INSTR_CNT
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             id_zero;
  logic             id_onehot;
  logic             mem_op;

  id_onehot_check u_chk (
    .id        (ID),
    .is_zero   (id_zero),
    .is_onehot (id_onehot)
  );

  assign mem_op    = id_onehot & (|ID[ID_XOR:ID_LDA]);
  assign STATE     = state_q;
  assign INSTR_CNT = cnt_q;

  // state and retire counter registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state, strobe decode and retire count
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    PC_INC  = 1'b0;
    PC_LD   = 1'b0;
    MAR_LD  = 1'b0;
    MAR_SRC = 1'b0;
    IR_LD   = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    ACC_LD  = 1'b0;
    ALU_SEL = ALU_PASS;
    HALTED  = 1'b0;
    ILLEGAL = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH0;
      end
      S_FETCH0: begin
        MAR_LD  = 1'b1;
        state_d = S_FETCH1;
      end
      S_FETCH1: begin
        MEM_RD  = 1'b1;
        IR_LD   = 1'b1;
        PC_INC  = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        MAR_LD  = mem_op;
        MAR_SRC = mem_op;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        cnt_d   = cnt_q + CNT_W'(1);
        ILLEGAL = ~id_zero & ~id_onehot;
        if (id_onehot) begin
          unique case (1'b1)
            ID[ID_LDA]: begin
              MEM_RD  = 1'b1;
              ACC_LD  = 1'b1;
              ALU_SEL = ALU_PASS;
            end
            ID[ID_STA]: MEM_WR = 1'b1;
            ID[ID_ADD]: begin
              MEM_RD  = 1'b1;
              ACC_LD  = 1'b1;
              ALU_SEL = ALU_ADD;
            end
            ID[ID_SUB]: begin
              MEM_RD  = 1'b1;
              ACC_LD  = 1'b1;
              ALU_SEL = ALU_SUB;
            end
            ID[ID_XOR]: begin
              MEM_RD  = 1'b1;
              ACC_LD  = 1'b1;
              ALU_SEL = ALU_XOR;
            end
            ID[ID_INC]: begin
              ACC_LD  = 1'b1;
              ALU_SEL = ALU_INC;
            end
            ID[ID_CLR]: begin
              ACC_LD  = 1'b1;
              ALU_SEL = ALU_CLR;
            end
            ID[ID_JMP]: PC_LD = 1'b1;
            ID[ID_JPZ]: PC_LD = Z;
            ID[ID_JPN]: PC_LD = N;
            default: ;
          endcase
        end
        if (id_onehot && ID[ID_HLT]) begin
          state_d = S_HALT;
        end else if (RUN) begin
          state_d = S_FETCH0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: begin
        HALTED = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_trisc_control_sequencer.sv
// Bench for the TRISC control sequencer.
// Directed and random instruction streams against a table model.
module tb_trisc_control_sequencer;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        RUN = 1'b0;
  logic [10:0] ID = '0;
  logic        Z = 1'b0;
  logic        N = 1'b0;
  logic        PC_INC, PC_LD, MAR_LD, MAR_SRC;
  logic        IR_LD, MEM_RD, MEM_WR, ACC_LD;
  logic [2:0]  ALU_SEL;
  logic        HALTED, ILLEGAL;
  logic [2:0]  STATE;
  logic [7:0]  INSTR_CNT;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  logic [13:0] obs;
  assign obs = {PC_INC, PC_LD, MAR_LD, MAR_SRC,
                IR_LD, MEM_RD, MEM_WR, ACC_LD,
                ALU_SEL, HALTED, ILLEGAL, 1'b0};

  trisc_control_sequencer #(.CNT_W(8)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .RUN       (RUN),
    .ID        (ID),
    .Z         (Z),
    .N         (N),
    .PC_INC    (PC_INC),
    .PC_LD     (PC_LD),
    .MAR_LD    (MAR_LD),
    .MAR_SRC   (MAR_SRC),
    .IR_LD     (IR_LD),
    .MEM_RD    (MEM_RD),
    .MEM_WR    (MEM_WR),
    .ACC_LD    (ACC_LD),
    .ALU_SEL   (ALU_SEL),
    .HALTED    (HALTED),
    .ILLEGAL   (ILLEGAL),
    .STATE     (STATE),
    .INSTR_CNT (INSTR_CNT)
  );

  always #5 CLK = ~CLK;

  // expected strobes for a step of the instruction cycle
  // p: 0 idle, 1 fetch0, 2 fetch1, 3 decode, 4 exec, 5 halt
  function automatic logic [13:0] exp_out(
    int p, logic [10:0] id, logic z, logic n);
    logic pci, pcl, marl, mars, irl, mrd, mwr, accl;
    logic hal, ill;
    logic [2:0] alu;
    int ones;
    {pci, pcl, marl, mars, irl, mrd, mwr, accl} = '0;
    {hal, ill} = '0;
    alu = 3'd0;
    ones = $countones(id);
    case (p)
      1: marl = 1'b1;
      2: begin mrd = 1'b1; irl = 1'b1; pci = 1'b1; end
      3: begin
        if (ones == 1 && (id & 11'h01F) != 0) begin
          marl = 1'b1;
          mars = 1'b1;
        end
      end
      4: begin
        if (ones > 1) ill = 1'b1;
        else begin
          case (id)
            11'h001: begin mrd = 1; accl = 1; alu = 0; end
            11'h002: mwr = 1'b1;
            11'h004: begin mrd = 1; accl = 1; alu = 1; end
            11'h008: begin mrd = 1; accl = 1; alu = 2; end
            11'h010: begin mrd = 1; accl = 1; alu = 3; end
            11'h020: begin accl = 1; alu = 4; end
            11'h040: begin accl = 1; alu = 5; end
            11'h080: pcl = 1'b1;
            11'h100: pcl = z;
            11'h200: pcl = n;
            default: ;
          endcase
        end
      end
      5: hal = 1'b1;
      default: ;
    endcase
    return {pci, pcl, marl, mars, irl, mrd, mwr, accl,
            alu, hal, ill, 1'b0};
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // one cycle in IDLE with RUN high; lands in FETCH0
  task automatic start();
    RUN = 1'b1;
    ID = 11'($urandom);
    #1;
    chk("idle_state", 32'(STATE), 0);
    chk("idle_out", 32'(obs), 0);
    tick();
  endtask

  // full instruction from FETCH0; RUN at the boundary is keep
  task automatic do_instr(
    logic [10:0] id, logic z, logic n, logic keep);
    int nxt;
    for (int p = 1; p <= 4; p++) begin
      ID = (p >= 3) ? id : 11'($urandom);
      Z = z;
      N = n;
      RUN = (p == 4) ? keep : 1'($urandom);
      #1;
      chk("step_state", 32'(STATE), 32'(p));
      chk("step_out", 32'(obs), 32'(exp_out(p, id, z, n)));
      tick();
    end
    exp_cnt = (exp_cnt + 1) % 256;
    chk("retire_cnt", 32'(INSTR_CNT), 32'(exp_cnt));
    if (id == 11'h400) nxt = 5;
    else nxt = keep ? 1 : 0;
    chk("next_state", 32'(STATE), 32'(nxt));
  endtask

  initial begin
    logic [10:0] rid;
    logic running;
    int r;

    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_state", 32'(STATE), 0);
    chk("rst_cnt", 32'(INSTR_CNT), 0);
    chk("rst_out", 32'(obs), 0);

    RUN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_hold", 32'(STATE), 0);
    end

    start();
    do_instr(11'h001, 1'b0, 1'b0, 1'b1);
    do_instr(11'h100, 1'b0, 1'b1, 1'b1);
    do_instr(11'h100, 1'b1, 1'b0, 1'b1);
    do_instr(11'h200, 1'b1, 1'b0, 1'b1);
    do_instr(11'h200, 1'b0, 1'b1, 1'b1);
    do_instr(11'h003, 1'b1, 1'b1, 1'b1);
    do_instr(11'h000, 1'b1, 1'b1, 1'b1);
    do_instr(11'h002, 1'b0, 1'b0, 1'b1);
    do_instr(11'h040, 1'b0, 1'b0, 1'b0);

    // random stream, long enough to wrap the counter
    running = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!running) begin
        RUN = 1'b0;
        for (int w = 0; w < int'($urandom_range(0, 2)); w++) begin
          #1;
          chk("pause_state", 32'(STATE), 0);
          tick();
        end
        start();
      end
      r = int'($urandom_range(0, 11));
      if (r < 10) rid = 11'(1 << r);
      else if (r == 10) rid = '0;
      else rid = 11'($urandom) | 11'h003;
      running = ($urandom_range(0, 3) != 0);
      do_instr(rid, 1'($urandom), 1'($urandom), running);
    end
    if (running) begin
      do_instr(11'h080, 1'b0, 1'b0, 1'b0);
    end

    // reset in the middle of an instruction
    start();
    RUN = 1'b1;
    tick();
    tick();
    #1;
    chk("mid_state", 32'(STATE), 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    RUN = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_state", 32'(STATE), 0);
    chk("mid_rst_cnt", 32'(INSTR_CNT), 0);

    // halt holds regardless of RUN until reset
    start();
    do_instr(11'h400, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      RUN = 1'b1;
      ID = 11'($urandom);
      #1;
      chk("halt_state", 32'(STATE), 5);
      chk("halt_out", 32'(obs), 32'(exp_out(5, ID, Z, N)));
      tick();
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    RUN = 1'b0;
    chk("halt_rst_state", 32'(STATE), 0);
    chk("halt_rst_cnt", 32'(INSTR_CNT), 0);
    chk("halt_rst_out", 32'(obs), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
